// File: rtl/iob_eth_csr_resp.sv
`default_nettype none
// ============================================================================
// Module   : iob_eth_csr_resp
// Purpose  : CPU-side IOb subordinate of the Ethernet core. It serves MODER,
//            RX_NBYTES, frame-byte TX/RX FIFOs and the shared BD memory.
// Revision : 1.0
// ============================================================================
module iob_eth_csr_resp #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int BD_ADDR_W  = 8,
    parameter int TXF_ADDR_W = 4,
    parameter int RXF_ADDR_W = 11
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  iob_valid_i,
    input  logic [ADDR_W-1:0]     iob_addr_i,
    input  logic [DATA_W-1:0]     iob_wdata_i,
    input  logic [DATA_W/8-1:0]   iob_wstrb_i,
    output logic                  iob_ready_o,
    output logic                  iob_rvalid_o,
    output logic [DATA_W-1:0]     iob_rdata_o,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    input  logic                  rx_last_i,
    output logic                  rx_ready_o,
    input  logic                  bd_we_i,
    input  logic [BD_ADDR_W-1:0]  bd_addr_i,
    input  logic [DATA_W-1:0]     bd_wdata_i,
    output logic [DATA_W-1:0]     bd_rdata_o,
    output logic [DATA_W-1:0]     moder_o
);

    localparam int                      c_NSTRB   = DATA_W / 8;
    localparam int                      c_NB_W    = 11;
    localparam logic [c_NB_W-1:0]       c_NB_MAX  = '1;
    localparam logic [c_NB_W-1:0]       c_NB_ONE  = c_NB_W'(1);
    localparam logic [TXF_ADDR_W:0]     c_TX_ONE  = (TXF_ADDR_W+1)'(1);
    localparam logic [RXF_ADDR_W:0]     c_RX_ONE  = (RXF_ADDR_W+1)'(1);
    localparam logic [TXF_ADDR_W:0]     c_TX_FULL = {1'b1, {TXF_ADDR_W{1'b0}}};
    localparam logic [RXF_ADDR_W:0]     c_RX_FULL = {1'b1, {RXF_ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0]       c_A_MODER  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0]       c_A_NBYTES = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]       c_A_FRAME  = ADDR_W'(2);
    localparam logic [ADDR_W-BD_ADDR_W-1:0] c_A_BD_PAGE = (ADDR_W-BD_ADDR_W)'(1);

    logic [DATA_W-1:0]     r_moder;
    logic [7:0]            r_tx_mem [2**TXF_ADDR_W];
    logic [TXF_ADDR_W:0]   r_tx_wptr;
    logic [TXF_ADDR_W:0]   r_tx_rptr;
    logic [7:0]            r_rx_mem [2**RXF_ADDR_W];
    logic [RXF_ADDR_W:0]   r_rx_wptr;
    logic [RXF_ADDR_W:0]   r_rx_rptr;
    logic [c_NB_W-1:0]     r_rx_cnt;
    logic [c_NB_W-1:0]     r_rx_nbytes;
    logic [DATA_W-1:0]     r_bd_mem [2**BD_ADDR_W];
    logic [DATA_W-1:0]     r_bd_cpu_rdata;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_rd_bd;
    logic                  r_rvalid;

    logic                  w_is_wr;
    logic                  w_sel_moder;
    logic                  w_sel_nbytes;
    logic                  w_sel_frame;
    logic                  w_sel_bd;
    logic                  w_stall;
    logic                  w_acc;
    logic                  w_acc_rd;
    logic                  w_tx_empty;
    logic                  w_tx_full;
    logic                  w_tx_push;
    logic                  w_tx_pop;
    logic                  w_rx_empty;
    logic                  w_rx_full;
    logic                  w_rx_push;
    logic                  w_rx_pop;
    logic                  w_bd_cpu_wr;
    logic [BD_ADDR_W-1:0]  w_bd_waddr;
    logic [DATA_W-1:0]     w_bd_wdata;
    logic [DATA_W-1:0]     w_rdata_mux;

    assign w_is_wr      = |iob_wstrb_i;
    assign w_sel_moder  = (iob_addr_i == c_A_MODER);
    assign w_sel_nbytes = (iob_addr_i == c_A_NBYTES);
    assign w_sel_frame  = (iob_addr_i == c_A_FRAME);
    assign w_sel_bd     = (iob_addr_i[ADDR_W-1:BD_ADDR_W] == c_A_BD_PAGE);

    assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
    assign w_tx_full  = ((r_tx_wptr ^ r_tx_rptr) == c_TX_FULL);
    assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
    assign w_rx_full  = ((r_rx_wptr ^ r_rx_rptr) == c_RX_FULL);

    // The core's BD write owns the shared port, so a colliding CPU BD access waits.
    assign w_stall = (w_sel_frame &  w_is_wr & w_tx_full)
                   | (w_sel_frame & ~w_is_wr & w_rx_empty)
                   | (w_sel_bd & bd_we_i);

    assign iob_ready_o = iob_valid_i & ~w_stall;
    assign w_acc       = iob_ready_o;
    assign w_acc_rd    = w_acc & ~w_is_wr;

    assign tx_valid_o = ~w_tx_empty & r_moder[1];
    assign tx_data_o  = r_tx_mem[r_tx_rptr[TXF_ADDR_W-1:0]];
    assign w_tx_push  = w_acc & w_is_wr & w_sel_frame;
    assign w_tx_pop   = tx_valid_o & tx_ready_i;

    assign rx_ready_o = r_moder[0] & ~w_rx_full & (r_rx_nbytes == '0);
    assign w_rx_push  = rx_valid_i & rx_ready_o;
    assign w_rx_pop   = w_acc_rd & w_sel_frame;

    assign w_bd_cpu_wr = w_acc & w_is_wr & w_sel_bd;
    assign w_bd_waddr  = bd_we_i ? bd_addr_i  : iob_addr_i[BD_ADDR_W-1:0];
    assign w_bd_wdata  = bd_we_i ? bd_wdata_i : iob_wdata_i;

    assign moder_o      = r_moder;
    assign iob_rvalid_o = r_rvalid;
    assign iob_rdata_o  = r_rd_bd ? r_bd_cpu_rdata : r_rdata;

    always_comb begin
        w_rdata_mux = '0;
        if (w_sel_moder) begin
            w_rdata_mux = r_moder;
        end else if (w_sel_nbytes) begin
            w_rdata_mux = DATA_W'(r_rx_nbytes);
        end else if (w_sel_frame) begin
            w_rdata_mux = DATA_W'(r_rx_mem[r_rx_rptr[RXF_ADDR_W-1:0]]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_moder     <= '0;
            r_tx_wptr   <= '0;
            r_tx_rptr   <= '0;
            r_rx_wptr   <= '0;
            r_rx_rptr   <= '0;
            r_rx_cnt    <= '0;
            r_rx_nbytes <= '0;
            r_rdata     <= '0;
            r_rd_bd     <= 1'b0;
            r_rvalid    <= 1'b0;
        end else begin
            if (w_acc & w_is_wr & w_sel_moder) begin
                for (int b = 0; b < c_NSTRB; b++) begin
                    if (iob_wstrb_i[b]) begin
                        r_moder[b*8 +: 8] <= iob_wdata_i[b*8 +: 8];
                    end
                end
            end

            if (w_tx_push) r_tx_wptr <= r_tx_wptr + c_TX_ONE;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + c_TX_ONE;
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + c_RX_ONE;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + c_RX_ONE;

            if (w_rx_pop && (r_rx_nbytes != '0)) begin
                r_rx_nbytes <= r_rx_nbytes - c_NB_ONE;
            end
            // Oversized frames pin both counters at the maximum instead of wrapping.
            if (w_rx_push) begin
                if (rx_last_i) begin
                    r_rx_nbytes <= (r_rx_cnt == c_NB_MAX) ? c_NB_MAX : r_rx_cnt + c_NB_ONE;
                    r_rx_cnt    <= '0;
                end else if (r_rx_cnt != c_NB_MAX) begin
                    r_rx_cnt <= r_rx_cnt + c_NB_ONE;
                end
            end

            r_rvalid <= w_acc_rd;
            if (w_acc_rd) begin
                r_rd_bd <= w_sel_bd;
                r_rdata <= w_rdata_mux;
            end
        end
    end

    // Storage arrays are left uncleared by reset; software initialises the BDs.
    always_ff @(posedge clk_i) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr[TXF_ADDR_W-1:0]] <= iob_wdata_i[7:0];
        if (w_rx_push) r_rx_mem[r_rx_wptr[RXF_ADDR_W-1:0]] <= rx_data_i;

        for (int b = 0; b < c_NSTRB; b++) begin
            if (bd_we_i || (w_bd_cpu_wr && iob_wstrb_i[b])) begin
                r_bd_mem[w_bd_waddr][b*8 +: 8] <= w_bd_wdata[b*8 +: 8];
            end
        end
        if (w_acc_rd & w_sel_bd) begin
            r_bd_cpu_rdata <= r_bd_mem[iob_addr_i[BD_ADDR_W-1:0]];
        end
        bd_rdata_o <= r_bd_mem[bd_addr_i];
    end

endmodule
`default_nettype wire

// File: tb/tb_iob_eth_csr_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_eth_csr_resp
// Purpose  : Directed self-checking bench for iob_eth_csr_resp.
// Revision : 1.0
// ============================================================================
module tb_iob_eth_csr_resp;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        iob_valid_i;
    logic [9:0]  iob_addr_i;
    logic [31:0] iob_wdata_i;
    logic [3:0]  iob_wstrb_i;
    logic        iob_ready_o;
    logic        iob_rvalid_o;
    logic [31:0] iob_rdata_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_last_i;
    logic        rx_ready_o;
    logic        bd_we_i;
    logic [7:0]  bd_addr_i;
    logic [31:0] bd_wdata_i;
    logic [31:0] bd_rdata_o;
    logic [31:0] moder_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    iob_eth_csr_resp dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .iob_valid_i  (iob_valid_i),
        .iob_addr_i   (iob_addr_i),
        .iob_wdata_i  (iob_wdata_i),
        .iob_wstrb_i  (iob_wstrb_i),
        .iob_ready_o  (iob_ready_o),
        .iob_rvalid_o (iob_rvalid_o),
        .iob_rdata_o  (iob_rdata_o),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i),
        .rx_data_i    (rx_data_i),
        .rx_valid_i   (rx_valid_i),
        .rx_last_i    (rx_last_i),
        .rx_ready_o   (rx_ready_o),
        .bd_we_i      (bd_we_i),
        .bd_addr_i    (bd_addr_i),
        .bd_wdata_i   (bd_wdata_i),
        .bd_rdata_o   (bd_rdata_o),
        .moder_o      (moder_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int seed, input int i);
        return 8'(seed + i * 3);
    endfunction

    // Drives at posedge+1, samples ready at negedge, returns at posedge+1 after the edge.
    task automatic bus_wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int limit, output bit done);
        int n = 0;
        iob_valid_i = 1'b1; iob_addr_i = a; iob_wdata_i = d; iob_wstrb_i = s;
        @(negedge clk_i);
        while (!iob_ready_o && n < limit) begin
            n++;
            @(negedge clk_i);
        end
        done = iob_ready_o;
        if (!done) begin
            iob_valid_i = 1'b0; iob_wstrb_i = 4'h0;
        end
        @(posedge clk_i); #1;
        iob_valid_i = 1'b0; iob_wstrb_i = 4'h0;
    endtask

    task automatic bus_rd(input logic [9:0] a, input int limit, output logic [31:0] rd,
                          output logic rv, output logic pre_rv, output bit done);
        int n = 0;
        iob_valid_i = 1'b1; iob_addr_i = a; iob_wstrb_i = 4'h0;
        @(negedge clk_i);
        pre_rv = iob_rvalid_o;
        while (!iob_ready_o && n < limit) begin
            n++;
            @(negedge clk_i);
        end
        done = iob_ready_o;
        if (!done) iob_valid_i = 1'b0;
        @(posedge clk_i); #1;
        iob_valid_i = 1'b0;
        rv = iob_rvalid_o;
        rd = iob_rdata_o;
    endtask

    task automatic wr_chk(input string tag, input logic [9:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        bit done;
        bus_wr(a, d, s, 8, done);
        chk({tag, "_accept"}, 32'(done), 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [9:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic rv, prv;
        bit done;
        bus_rd(a, 8, rd, rv, prv, done);
        chk({tag, "_accept"}, 32'(done), 32'd1);
        chk({tag, "_rvalid"}, 32'(rv), 32'd1);
        chk(tag, rd, exp);
    endtask

    task automatic rx_frame(input int n, input int seed, input bit with_last, output int miss);
        miss = 0;
        for (int i = 0; i < n; i++) begin
            int w = 0;
            rx_valid_i = 1'b1;
            rx_data_i  = pat(seed, i);
            rx_last_i  = with_last && (i == n - 1);
            @(negedge clk_i);
            while (!rx_ready_o && w < 8) begin
                w++;
                @(negedge clk_i);
            end
            if (!rx_ready_o) begin
                miss++;
                rx_valid_i = 1'b0;
            end
            @(posedge clk_i); #1;
        end
        rx_valid_i = 1'b0;
        rx_last_i  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic rv, prv;
        bit done;
        int miss;

        rst_n_i = 1'b0; iob_valid_i = 1'b0; iob_addr_i = '0; iob_wdata_i = '0; iob_wstrb_i = '0;
        tx_ready_i = 1'b0; rx_data_i = '0; rx_valid_i = 1'b0; rx_last_i = 1'b0;
        bd_we_i = 1'b0; bd_addr_i = '0; bd_wdata_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_rvalid",   32'(iob_rvalid_o), 32'd0);
        chk("rst_rdata",    iob_rdata_o,       32'd0);
        chk("rst_tx_valid", 32'(tx_valid_o),   32'd0);
        chk("rst_rx_ready", 32'(rx_ready_o),   32'd0);
        chk("rst_moder",    moder_o,           32'd0);
        rst_n_i = 1'b1;

        // MODER reset read, rvalid timing and strobed writes
        bus_rd(10'h000, 8, rd, rv, prv, done);
        chk("moder_rd_accept", 32'(done), 32'd1);
        chk("moder_pre_rvalid", 32'(prv), 32'd0);
        chk("moder_rvalid", 32'(rv), 32'd1);
        chk("moder_reset_val", rd, 32'd0);
        @(posedge clk_i); #1;
        chk("rvalid_single_pulse", 32'(iob_rvalid_o), 32'd0);
        chk("rdata_hold", iob_rdata_o, 32'd0);

        wr_chk("moder_wr3", 10'h000, 32'h0000_0003, 4'h1);
        chk("moder_o_3", moder_o, 32'h0000_0003);
        rd_chk("moder_rd3", 10'h000, 32'h0000_0003);
        wr_chk("moder_wr_b2", 10'h000, 32'hABCD_FF00, 4'h4);
        rd_chk("moder_rd_b2", 10'h000, 32'h00CD_0003);

        wr_chk("nbytes_wr_ignored", 10'h001, 32'hFFFF_FFFF, 4'hF);
        rd_chk("nbytes_zero", 10'h001, 32'd0);
        rd_chk("unmapped_003", 10'h003, 32'd0);
        rd_chk("unmapped_3ff", 10'h3FF, 32'd0);
        wr_chk("moder_clear", 10'h000, 32'd0, 4'hF);

        // TX FIFO fill with TXEN=0, 17th write stalls
        tx_ready_i = 1'b1;
        miss = 0;
        for (int i = 0; i < 16; i++) begin
            bus_wr(10'h002, 32'(i), 4'h1, 8, done);
            if (!done) miss++;
        end
        chk("tx_fill_16", 32'(miss), 32'd0);
        chk("tx_valid_txen0", 32'(tx_valid_o), 32'd0);
        bus_wr(10'h002, 32'h10, 4'h1, 4, done);
        chk("tx_full_stall", 32'(done), 32'd0);

        wr_chk("moder_txen", 10'h000, 32'h3, 4'hF);
        for (int i = 0; i < 16; i++) begin
            chk("tx_out_valid", 32'(tx_valid_o), 32'd1);
            chk("tx_out_data", 32'(tx_data_o), 32'(i));
            @(posedge clk_i); #1;
        end
        chk("tx_drained", 32'(tx_valid_o), 32'd0);
        wr_chk("tx_17th", 10'h002, 32'h10, 4'h1);
        tx_ready_i = 1'b0;
        chk("tx_17th_valid", 32'(tx_valid_o), 32'd1);
        chk("tx_17th_data", 32'(tx_data_o), 32'h10);
        wr_chk("moder_txen_off", 10'h000, 32'h1, 4'hF);
        chk("txen_off_hold", 32'(tx_valid_o), 32'd0);
        wr_chk("moder_txen_on", 10'h000, 32'h3, 4'hF);
        chk("txen_on_valid", 32'(tx_valid_o), 32'd1);
        chk("txen_on_data", 32'(tx_data_o), 32'h10);
        tx_ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("tx_final_pop", 32'(tx_valid_o), 32'd0);
        tx_ready_i = 1'b0;

        // 60-byte RX frame
        rx_frame(60, 5, 1'b1, miss);
        chk("rx60_accept", 32'(miss), 32'd0);
        chk("rx_pending_block", 32'(rx_ready_o), 32'd0);
        rd_chk("rx60_nbytes", 10'h001, 32'd60);
        for (int i = 0; i < 60; i++) begin
            rd_chk("rx60_pop", 10'h002, 32'(pat(5, i)));
        end
        chk("rx_ready_reassert", 32'(rx_ready_o), 32'd1);
        rd_chk("rx60_nbytes_after", 10'h001, 32'd0);

        // Empty-FIFO read stall, then a single byte arrives
        iob_valid_i = 1'b1; iob_addr_i = 10'h002; iob_wstrb_i = 4'h0;
        @(negedge clk_i);
        chk("rx_empty_stall", 32'(iob_ready_o), 32'd0);
        @(posedge clk_i); #1;
        rx_valid_i = 1'b1; rx_data_i = 8'hA5; rx_last_i = 1'b1;
        @(negedge clk_i);
        chk("rx_empty_stall2", 32'(iob_ready_o), 32'd0);
        @(posedge clk_i); #1;
        rx_valid_i = 1'b0; rx_last_i = 1'b0;
        @(negedge clk_i);
        chk("rx_byte_ready", 32'(iob_ready_o), 32'd1);
        @(posedge clk_i); #1;
        iob_valid_i = 1'b0;
        chk("rx_a5_rvalid", 32'(iob_rvalid_o), 32'd1);
        chk("rx_a5_data", iob_rdata_o, 32'h0000_00A5);

        // BD arbitration: core write wins, CPU write lands one cycle later
        iob_valid_i = 1'b1; iob_addr_i = 10'h180; iob_wdata_i = 32'hC000_0000; iob_wstrb_i = 4'hF;
        bd_we_i = 1'b1; bd_addr_i = 8'h80; bd_wdata_i = 32'h0000_1234;
        @(negedge clk_i);
        chk("bd_cpu_stall", 32'(iob_ready_o), 32'd0);
        @(posedge clk_i); #1;
        bd_we_i = 1'b0;
        @(negedge clk_i);
        chk("bd_cpu_go", 32'(iob_ready_o), 32'd1);
        @(posedge clk_i); #1;
        iob_valid_i = 1'b0; iob_wstrb_i = 4'h0;
        chk("bd_core_rd_old", bd_rdata_o, 32'h0000_1234);
        @(posedge clk_i); #1;
        chk("bd_core_rd_new", bd_rdata_o, 32'hC000_0000);
        rd_chk("bd_cpu_rd", 10'h180, 32'hC000_0000);
        wr_chk("bd_wr_full", 10'h181, 32'hAABB_CCDD, 4'hF);
        wr_chk("bd_wr_b1", 10'h181, 32'h1122_3344, 4'h2);
        rd_chk("bd_strobe_rd", 10'h181, 32'hAABB_33DD);

        // Reset mid-frame, with a read accepted on the reset edge
        rx_frame(30, 9, 1'b0, miss);
        chk("rx30_accept", 32'(miss), 32'd0);
        iob_valid_i = 1'b1; iob_addr_i = 10'h000; iob_wstrb_i = 4'h0;
        rst_n_i = 1'b0;
        @(posedge clk_i); #1;
        iob_valid_i = 1'b0;
        rst_n_i = 1'b1;
        chk("rst_mid_rvalid_drop", 32'(iob_rvalid_o), 32'd0);
        chk("rst_mid_moder", moder_o, 32'd0);
        chk("rst_mid_rx_ready", 32'(rx_ready_o), 32'd0);
        wr_chk("rst_mid_rxen", 10'h000, 32'h1, 4'h1);
        rd_chk("rst_mid_nbytes", 10'h001, 32'd0);
        chk("rst_mid_rx_ready_on", 32'(rx_ready_o), 32'd1);
        rx_frame(64, 64, 1'b1, miss);
        chk("rx64_accept", 32'(miss), 32'd0);
        rd_chk("rx64_nbytes", 10'h001, 32'd64);
        rd_chk("rx64_first_byte", 10'h002, 32'(pat(64, 0)));
        rd_chk("rx64_second_byte", 10'h002, 32'(pat(64, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
